// File: rtl/memory_readout_tx_if.sv
// Bus between the memory-readout serializer and its environment:
// request and captured word in, serial line and status out.
interface memory_readout_tx_if;
   localparam int unsigned DATA_W = 35;

   logic              req;
   logic [DATA_W-1:0] mem_dout;
   logic              txd;
   logic              busy;
   logic              done;

   modport master (output req, mem_dout, input txd, busy, done);
   modport slave  (input req, mem_dout, output txd, busy, done);
endinterface

// File: rtl/memory_readout_tx.sv
// Captures the 35-bit memory word on request and shifts it out as a framed
// serial stream: start, 35 data bits LSB first, parity, stop.
module memory_readout_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic               clk,
   input  logic               arst,
   memory_readout_tx_if.slave bus
);
   localparam int unsigned     DATA_W   = 35;
   localparam int unsigned     IDX_W    = 6;
   localparam int unsigned     DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t            r_state,  w_state_nxt;
   logic [DATA_W-1:0] r_shadow, w_shadow_nxt;
   logic              r_par,    w_par_nxt;
   logic [IDX_W-1:0]  r_idx,    w_idx_nxt;
   logic [DIV_W-1:0]  r_div,    w_div_nxt;
   logic              r_txd,    w_txd_nxt;
   logic              r_busy,   w_busy_nxt;
   logic              r_done,   w_done_nxt;
   logic              w_bit_end;

   assign w_bit_end = (r_div == DIV_LAST);

   // State register; outputs are registered from their next-state values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state  <= S_IDLE;
         r_shadow <= '0;
         r_par    <= 1'b0;
         r_idx    <= '0;
         r_div    <= '0;
         r_txd    <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_par    <= w_par_nxt;
         r_idx    <= w_idx_nxt;
         r_div    <= w_div_nxt;
         r_txd    <= w_txd_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state logic; divider wraps at every bit boundary.
   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      w_par_nxt    = r_par;
      w_idx_nxt    = r_idx;
      w_div_nxt    = w_bit_end ? '0 : r_div + DIV_W'(1);
      w_done_nxt   = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_div_nxt = '0;
            if (bus.req) begin
               w_shadow_nxt = bus.mem_dout;
               w_par_nxt    = (^bus.mem_dout) ^ PARITY_ODD;
               w_idx_nxt    = '0;
               w_state_nxt  = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_idx == IDX_LAST) w_state_nxt = S_PARITY;
               else                   w_idx_nxt   = r_idx + IDX_W'(1);
            end
         end
         S_PARITY: begin
            if (w_bit_end) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Line level for the upcoming cycle, derived from the next state.
   always_comb begin
      w_txd_nxt  = 1'b1;
      w_busy_nxt = (w_state_nxt != S_IDLE);
      unique case (w_state_nxt)
         S_IDLE:   w_txd_nxt = 1'b1;
         S_START:  w_txd_nxt = 1'b0;
         S_DATA:   w_txd_nxt = w_shadow_nxt[w_idx_nxt];
         S_PARITY: w_txd_nxt = w_par_nxt;
         S_STOP:   w_txd_nxt = 1'b1;
         default:  w_txd_nxt = 1'b1;
      endcase
   end

   assign bus.txd  = r_txd;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
endmodule

// File: tb/tb_memory_readout_tx.sv
// Directed bench for memory_readout_tx: frame vectors on N=4 even/odd
// instances plus reset and back-to-back sequences on an N=1 instance.
module tb_memory_readout_tx;
   localparam int unsigned N     = 4;
   localparam int unsigned FRAME = 38 * N;
   localparam int unsigned F1    = 39;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   memory_readout_tx_if if_e ();
   memory_readout_tx_if if_o ();
   memory_readout_tx_if if_1 ();

   memory_readout_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_dut_e (.clk(clk), .arst(arst), .bus(if_e));
   memory_readout_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_dut_o (.clk(clk), .arst(arst), .bus(if_o));
   memory_readout_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_dut_1 (.clk(clk), .arst(arst), .bus(if_1));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          sel;
      logic [34:0] data;
      logic        exp_par;
      bit          disturb;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic r, input logic [34:0] d);
      case (sel)
         0:       begin if_e.req = r; if_e.mem_dout = d; end
         1:       begin if_o.req = r; if_o.mem_dout = d; end
         default: begin if_1.req = r; if_1.mem_dout = d; end
      endcase
   endtask

   function automatic logic txd_of(input int sel);
      case (sel)
         0:       return if_e.txd;
         1:       return if_o.txd;
         default: return if_1.txd;
      endcase
   endfunction

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return if_e.busy;
         1:       return if_o.busy;
         default: return if_1.busy;
      endcase
   endfunction

   function automatic logic done_of(input int sel);
      case (sel)
         0:       return if_e.done;
         1:       return if_o.done;
         default: return if_1.done;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One N=4 frame: request, record the line, then decode and compare.
   task automatic run_frame(input int sel, input logic [34:0] d, input logic exp_par, input bit disturb);
      logic [FRAME-1:0] line;
      logic [34:0]      got;
      int bad_busy = 0;
      int bad_done = 0;
      int bad_hold = 0;
      int bad_idle = 0;
      drive(sel, 1'b1, d);
      step();
      drive(sel, 1'b0, d);
      for (int c = 0; c < int'(FRAME); c++) begin
         line[c] = txd_of(sel);
         if (busy_of(sel) !== 1'b1) bad_busy++;
         if (done_of(sel) !== 1'b0) bad_done++;
         if (disturb) drive(sel, (c == 20 || c == 60 || c == 100), 35'h0);
         step();
      end
      check("done_at_end",  64'(done_of(sel)), 64'd1);
      check("busy_at_end",  64'(busy_of(sel)), 64'd0);
      check("txd_at_end",   64'(txd_of(sel)),  64'd1);
      for (int b = 0; b < 38; b++)
         for (int j = 1; j < int'(N); j++)
            if (line[b*int'(N)+j] !== line[b*int'(N)]) bad_hold++;
      for (int i = 0; i < 35; i++) got[i] = line[(1+i)*int'(N)];
      check("start_bit",    64'(line[0]),        64'd0);
      check("data_bits",    64'(got),            64'(d));
      check("parity_bit",   64'(line[36*N]),     64'(exp_par));
      check("stop_bit",     64'(line[37*N]),     64'd1);
      check("bit_hold",     64'(bad_hold),       64'd0);
      check("busy_frame",   64'(bad_busy),       64'd0);
      check("done_early",   64'(bad_done),       64'd0);
      for (int c = 0; c < 4; c++) begin
         step();
         if (done_of(sel) !== 1'b0 || busy_of(sel) !== 1'b0 || txd_of(sel) !== 1'b1) bad_idle++;
      end
      check("idle_after",   64'(bad_idle),       64'd0);
   endtask

   vec_t vecs[7];

   initial begin
      int bad;
      logic [34:0] d1;

      vecs[0] = '{0, 35'h0_0000_0001, 1'b1, 1'b0};
      vecs[1] = '{0, 35'h7_FFFF_FFFF, 1'b1, 1'b0};
      vecs[2] = '{1, 35'h7_FFFF_FFFF, 1'b0, 1'b0};
      vecs[3] = '{0, 35'h0_0000_0003, 1'b0, 1'b0};
      vecs[4] = '{1, 35'h0_0000_0003, 1'b1, 1'b0};
      vecs[5] = '{0, 35'h1_2345_6789, 1'b1, 1'b1};
      vecs[6] = '{1, 35'h5_5555_5555, 1'b1, 1'b0};

      // Reset held with a pending request on every instance
      arst = 1'b1;
      for (int s = 0; s < 3; s++) drive(s, 1'b1, 35'h5_5555_5555);
      #1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         for (int s = 0; s < 3; s++)
            if (txd_of(s) !== 1'b1 || busy_of(s) !== 1'b0 || done_of(s) !== 1'b0) bad++;
         step();
      end
      check("reset_outputs", 64'(bad), 64'd0);
      for (int s = 0; s < 3; s++) drive(s, 1'b0, 35'h5_5555_5555);
      arst = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         for (int s = 0; s < 3; s++)
            if (txd_of(s) !== 1'b1 || busy_of(s) !== 1'b0 || done_of(s) !== 1'b0) bad++;
      end
      check("idle_after_reset", 64'(bad), 64'd0);

      for (int v = 0; v < 7; v++)
         run_frame(vecs[v].sel, vecs[v].data, vecs[v].exp_par, vecs[v].disturb);

      // Reset during data bit 10 (cycles 44..47 after acceptance)
      drive(0, 1'b1, 35'h2_AAAA_5555);
      step();
      drive(0, 1'b0, 35'h2_AAAA_5555);
      repeat (45) step();
      check("busy_before_rst", 64'(busy_of(0)), 64'd1);
      arst = 1'b1;
      #1;
      check("rst_mid_txd",  64'(txd_of(0)),  64'd1);
      check("rst_mid_busy", 64'(busy_of(0)), 64'd0);
      check("rst_mid_done", 64'(done_of(0)), 64'd0);
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (txd_of(0) !== 1'b1 || busy_of(0) !== 1'b0 || done_of(0) !== 1'b0) bad++;
      end
      arst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (txd_of(0) !== 1'b1 || busy_of(0) !== 1'b0 || done_of(0) !== 1'b0) bad++;
      end
      check("rst_mid_quiet", 64'(bad), 64'd0);
      run_frame(0, 35'h0_0000_00AA, 1'b0, 1'b0);

      // Held request at N=1: 38-clock frames plus one idle clock each
      d1 = 35'h0_0000_0003;
      drive(2, 1'b1, d1);
      step();
      bad = 0;
      begin
         int n_done = 0;
         int bad_busy = 0;
         for (int c = 0; c < 3*int'(F1); c++) begin
            int  pos;
            logic exp_txd;
            pos = c % int'(F1);
            if      (pos == 0)  exp_txd = 1'b0;
            else if (pos <= 35) exp_txd = d1[pos-1];
            else if (pos == 36) exp_txd = 1'b0;
            else                exp_txd = 1'b1;
            if (txd_of(2) !== exp_txd) bad++;
            if (busy_of(2) !== (pos != 38)) bad_busy++;
            if (done_of(2) === 1'b1) begin
               n_done++;
               if (pos != 38) bad++;
            end
            if (c == 3*int'(F1) - 1) drive(2, 1'b0, d1);
            step();
         end
         check("n1_txd_stream", 64'(bad),      64'd0);
         check("n1_busy",       64'(bad_busy), 64'd0);
         check("n1_done_count", 64'(n_done),   64'd3);
         check("n1_idle_after", 64'(busy_of(2)), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
